// File: rtl/nios2_loader_pkg.sv
// Shared types and constants for the on-chip RAM image loader.
// Pure declarations: no latency, no flow control.
package nios2_loader_pkg;

    localparam int DEPTH_DEF  = 16000;
    localparam int ADDR_W_DEF = 14;
    localparam int CNT_W_DEF  = 16;
    localparam int LANES      = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/nios2_loader_packer.sv
// Packs stream bytes little-endian into a 32-bit word with byteenables; one byte per push.
// word_full flags (combinationally) the push that completes the word; the caller stops pushing until clear.
module nios2_loader_packer
    import nios2_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        push,
    input  logic        last,
    input  logic [7:0]  s_data,
    output logic [31:0] word,
    output logic [3:0]  be,
    output logic        word_full
);

    logic [1:0] lane;

    // The final byte of the image closes a word early, leaving upper lanes zero.
    assign word_full = push && ((lane == 2'(LANES - 1)) || last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane <= '0;
            word <= '0;
            be   <= '0;
        end else if (clear) begin
            lane <= '0;
            word <= '0;
            be   <= '0;
        end else if (push) begin
            word[8*lane +: 8] <= s_data;
            be[lane]          <= 1'b1;
            lane              <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/nios2_onchip_memory2_1_loader.sv
// Loads a byte stream into the on-chip RAM as packed words; CPU passes through when idle.
// One word per 5 cycles at full stream rate; s_ready drops during the write cycle, CPU is stalled while busy.
module nios2_onchip_memory2_1_loader
    import nios2_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [3:0]        cpu_byteenable,
    input  logic              cpu_chipselect,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic              error_q;

    logic [CNT_W:0]    words_needed;
    logic [ADDR_W+1:0] end_addr;
    logic              range_bad;
    logic              handshake;
    logic [31:0]       word;
    logic [3:0]        be;
    logic              word_full;

    // Word count fits ADDR_W+2 bits for any CNT_W-bit byte count, so the sum cannot wrap.
    assign words_needed = ({1'b0, byte_count} + (CNT_W + 1)'(3)) >> 2;
    assign end_addr     = (ADDR_W + 2)'(base_addr) + (ADDR_W + 2)'(words_needed);
    assign range_bad    = end_addr > (ADDR_W + 2)'(DEPTH);

    assign handshake = (state == FILL) && s_valid;

    nios2_loader_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     ((state == IDLE) || (state == WRITE)),
        .push      (handshake),
        .last      (remaining == CNT_W'(1)),
        .s_data    (s_data),
        .word      (word),
        .be        (be),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            error_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        error_q   <= range_bad && (byte_count != '0);
                        addr      <= base_addr;
                        remaining <= byte_count;
                    end
                end
                FILL: begin
                    if (handshake) begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                WRITE: begin
                    addr <= addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((byte_count == '0) || range_bad) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                if (word_full) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = (remaining == '0) ? DONE : FILL;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_ready         = (state == FILL);
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign error           = error_q;
    assign cpu_waitrequest = busy;
    assign mem_clken       = 1'b1;

    // RAM port mux: CPU owns the port only in IDLE; the loader drives it only in WRITE.
    always_comb begin
        mem_address    = addr;
        mem_byteenable = 4'b0000;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = 32'h0;
        if (state == IDLE) begin
            mem_address    = cpu_address;
            mem_byteenable = cpu_byteenable;
            mem_chipselect = cpu_chipselect;
            mem_write      = cpu_write;
            mem_writedata  = cpu_writedata;
        end else if (state == WRITE) begin
            mem_byteenable = be;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_writedata  = word;
        end
    end

endmodule

// File: tb/tb_nios2_onchip_memory2_1_loader.sv
// Randomized bench for the RAM image loader: a job-level model predicts every RAM write,
// done timing and error flag; a per-cycle monitor checks the RAM port against it.
module tb_nios2_onchip_memory2_1_loader;

    localparam int ADDR_W = 14;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 16000;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  byte_count;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] cpu_address;
    logic [3:0]        cpu_byteenable;
    logic              cpu_chipselect;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic              cpu_waitrequest;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;

    nios2_onchip_memory2_1_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .byte_count      (byte_count),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .cpu_address     (cpu_address),
        .cpu_byteenable  (cpu_byteenable),
        .cpu_chipselect  (cpu_chipselect),
        .cpu_write       (cpu_write),
        .cpu_writedata   (cpu_writedata),
        .cpu_waitrequest (cpu_waitrequest),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_clken       (mem_clken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stream[$];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         chk_en = 0;
    bit         cpu_rand = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word w of an image: bytes 4w..4w+3 little-endian, lanes past the end are zero and disabled.
    function automatic wr_t model_word(input int base, input int w, input int cnt);
        wr_t r;
        r.addr = base + w;
        r.data = 32'h0;
        r.be   = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (4 * w + k < cnt) begin
                r.data[8*k +: 8] = stream[4*w + k];
                r.be[k]          = 1'b1;
            end
        end
        return r;
    endfunction

    // CPU hammers the port with random requests, idle or not.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (cpu_rand) begin
                cpu_address    = ADDR_W'($urandom);
                cpu_byteenable = 4'($urandom);
                cpu_chipselect = 1'($urandom);
                cpu_write      = 1'($urandom);
                cpu_writedata  = $urandom;
            end
        end
    end

    // Port monitor: CPU pass-through when idle, otherwise only the predicted loader writes.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("waitrequest_vs_busy", 64'(cpu_waitrequest), 64'(busy));
            chk("clken", 64'(mem_clken), 64'(1));
            if (!busy) begin
                chk("passthrough",
                    64'({mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata}),
                    64'({cpu_address, cpu_byteenable, cpu_chipselect, cpu_write, cpu_writedata}));
            end else if (mem_chipselect || mem_write) begin
                if (exp_q.size() == 0) begin
                    chk("stray_mem_access", 64'({mem_chipselect, mem_write}), 64'(0));
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_strobe", 64'({mem_chipselect, mem_write}), 64'(2'b11));
                    chk("wr_addr", 64'(mem_address), 64'(w.addr));
                    chk("wr_data", 64'(mem_writedata), 64'(w.data));
                    chk("wr_be", 64'(mem_byteenable), 64'(w.be));
                end
            end
        end
    end

    // mode: 0 full rate, 1 valid every other cycle, 2 random valid. abort_at>=0 resets after that many bytes.
    task automatic run_job(input int base, input int cnt, input int mode, input int abort_at, input bit seq);
        int W, acc, cyc, done_cyc, nbusy, exp_lat;
        bit exp_err;
        stream.delete();
        for (int i = 0; i < cnt; i++) begin
            stream.push_back(seq ? 8'(i + 1) : 8'($urandom));
        end
        W       = (cnt + 3) / 4;
        exp_err = (cnt != 0) && (base + W > DEPTH);
        if (!exp_err) begin
            for (int w = 0; w < W; w++) begin
                if (abort_at < 0 || 4 * (w + 1) <= abort_at) exp_q.push_back(model_word(base, w, cnt));
            end
        end
        @(negedge clk);
        start      = 1'b1;
        base_addr  = ADDR_W'(base);
        byte_count = CNT_W'(cnt);
        acc = 0; cyc = 0; done_cyc = 0; nbusy = 0;
        while (done_cyc == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            // A start outside IDLE, with different parameters, must be ignored.
            start      = (cyc == 3);
            base_addr  = ADDR_W'($urandom);
            byte_count = CNT_W'($urandom_range(1, 40));
            if (abort_at >= 0 && acc == abort_at) begin
                reset_n = 1'b0;
                break;
            end
            s_valid = (acc < cnt) && ((mode == 0) || (mode == 1 && cyc % 2 == 1) ||
                                      (mode == 2 && $urandom_range(0, 2) != 0));
            s_data  = (acc < cnt) ? stream[acc] : 8'h00;
            if (busy) nbusy++;
            if (done) done_cyc = cyc;
            if (s_valid && s_ready) acc++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (abort_at >= 0) begin
            repeat (2) @(negedge clk);
            chk("abort_reset_outputs", 64'({s_ready, busy, done, error}), 64'(0));
            chk("abort_writes_seen", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
            reset_n = 1'b1;
            return;
        end
        if (done_cyc == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout actual=no done after %0d cycles required=done pulse", cyc);
            exp_q.delete();
            return;
        end
        exp_lat = (exp_err || cnt == 0) ? 1 : cnt + W + 1;
        if (mode == 0 || exp_lat == 1) begin
            chk("done_latency", 64'(done_cyc), 64'(exp_lat));
            chk("busy_cycles", 64'(nbusy), 64'(exp_lat));
        end else begin
            chk("busy_cycles", 64'(nbusy), 64'(done_cyc));
        end
        chk("bytes_consumed", 64'(acc), 64'(exp_err ? 0 : cnt));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("error_flag", 64'(error), 64'(exp_err));
        chk("idle_after_job", 64'({busy, s_ready}), 64'(0));
        chk("writes_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        wr_t p;
        reset_n        = 1'b0;
        start          = 1'b0;
        base_addr      = '0;
        byte_count     = '0;
        s_data         = 8'h00;
        s_valid        = 1'b0;
        cpu_address    = '0;
        cpu_byteenable = 4'h0;
        cpu_chipselect = 1'b0;
        cpu_write      = 1'b0;
        cpu_writedata  = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({s_ready, busy, done, error}), 64'(0));
        reset_n = 1'b1;
        chk_en  = 1'b1;

        @(negedge clk);
        cpu_address    = 14'h10;
        cpu_writedata  = 32'hDEADBEEF;
        cpu_byteenable = 4'hF;
        cpu_chipselect = 1'b1;
        cpu_write      = 1'b1;
        #1;
        chk("pt_addr", 64'(mem_address), 64'(14'h10));
        chk("pt_data", 64'(mem_writedata), 64'(32'hDEADBEEF));
        chk("pt_ctl", 64'({mem_byteenable, mem_chipselect, mem_write}), 64'(6'b111111));
        chk("pt_wait", 64'(cpu_waitrequest), 64'(0));

        stream.delete();
        for (int i = 0; i < 8; i++) stream.push_back(8'(i + 1));
        p = model_word(0, 0, 8);
        chk("model_w0", 64'({p.data, p.be}), 64'({32'h04030201, 4'hF}));
        p = model_word(0, 1, 8);
        chk("model_w1", 64'({p.data, p.be}), 64'({32'h08070605, 4'hF}));
        p = model_word(5, 1, 6);
        chk("model_partial", 64'({p.data, p.be}), 64'({32'h00000605, 4'h3}));
        chk("model_partial_addr", 64'(p.addr), 64'(6));

        cpu_rand = 1'b1;
        run_job(0, 8, 0, -1, 1'b1);
        run_job(5, 6, 0, -1, 1'b1);
        run_job(15999, 8, 0, -1, 1'b0);
        run_job(0, 0, 0, -1, 1'b0);
        run_job(15999, 4, 0, -1, 1'b0);
        run_job(15998, 9, 0, -1, 1'b0);
        run_job(0, 8, 1, -1, 1'b1);
        run_job(300, 13, 2, -1, 1'b0);
        run_job(100, 8, 0, 6, 1'b1);
        run_job(200, 8, 0, -1, 1'b1);
        for (int j = 0; j < 14; j++) begin
            int b, c, m;
            c = $urandom_range(0, 23);
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(15990, 16383) : $urandom_range(0, 15000);
            m = $urandom_range(0, 2);
            run_job(b, c, m, -1, 1'b0);
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
